// File: rtl/memory_game_pkg.sv
// memory_game_pkg: shared constants, FSM state encoding and counter-width helper for the pairs game.
package memory_game_pkg;
    localparam int NUM_CARDS = 6;
    localparam int CARD_W = 4;
    localparam int IDX_W = 3;
    localparam logic [NUM_CARDS-1:0] ALL_MATCHED = 6'b111111;
    typedef enum logic [2:0] {IDLE, PICK1, PICK2, SHOW, RESOLVE, DONE} state_t;
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/reveal_timer.sv
// reveal_timer: loadable down-counter that holds at zero; done flags a zero count.
module reveal_timer
    import memory_game_pkg::*;
#(
    parameter int SHOW_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [cnt_w(SHOW_CYCLES)-1:0] load_val,
    output logic                          done
);
    localparam int W = cnt_w(SHOW_CYCLES);
    logic [W-1:0] count_q, count_d;
    assign count_d = load ? load_val : done ? count_q : count_q - 1'b1;
    assign done = count_q == '0;
    always_ff @(posedge clk or negedge rst)
        if (!rst) count_q <= '0;
        else count_q <= count_d;
endmodule

// File: rtl/pair_match_checker.sv
// pair_match_checker: runs one pairs game over six latched card values against player picks.
// Define MEMORY_GAME_MISS_LIMIT_EN to end the game as lost after MAX_MISSES mismatches.
module pair_match_checker
    import memory_game_pkg::*;
#(
    parameter int SHOW_CYCLES = 4,
    parameter int MAX_MISSES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CARD_W-1:0]    card_a,
    input  logic [CARD_W-1:0]    card_b,
    input  logic [CARD_W-1:0]    card_c,
    input  logic [CARD_W-1:0]    card_d,
    input  logic [CARD_W-1:0]    card_e,
    input  logic [CARD_W-1:0]    card_f,
    input  logic [IDX_W-1:0]     sel,
    input  logic                 sel_valid,
    output logic [NUM_CARDS-1:0] revealed,
    output logic [NUM_CARDS-1:0] matched,
    output logic [7:0]           tries,
    output logic                 busy,
    output logic                 sel_err,
    output logic                 win,
    output logic                 lose
);
    localparam int TW = cnt_w(SHOW_CYCLES);

    if (SHOW_CYCLES < 1 || MAX_MISSES < 1 || MAX_MISSES > 15) begin : g_bad_param
        $error("pair_match_checker: SHOW_CYCLES must be >= 1 and MAX_MISSES in 1..15");
    end

    state_t state_q, state_d;
    logic [NUM_CARDS-1:0][CARD_W-1:0] cards_q;
    logic [NUM_CARDS-1:0] revealed_q, revealed_d, matched_q, matched_d;
    logic [IDX_W-1:0] idx1_q, idx1_d, idx2_q, idx2_d;
    logic [7:0] tries_q, tries_d;
    logic sel_err_q, sel_err_d, win_q, win_d;
    logic tmr_load, tmr_done, pair_eq, out_of_misses;
    logic [2**IDX_W-1:0] taken;
    logic [NUM_CARDS-1:0] sel_bit, hit, new_matched;
    logic sel_free;

    // Indices 6 and 7 read as already taken, so one lookup rejects both cases.
    assign taken = {{(2**IDX_W-NUM_CARDS){1'b1}}, matched_q};
    assign sel_free = !taken[sel];
    assign sel_bit = NUM_CARDS'(1) << sel;
    assign pair_eq = cards_q[idx1_q] == cards_q[idx2_q];
    assign hit = pair_eq ? (NUM_CARDS'(1) << idx1_q) | (NUM_CARDS'(1) << idx2_q) : '0;
    assign new_matched = matched_q | hit;
    assign tmr_load = !load && state_q == PICK2 && sel_valid && sel_free && sel != idx1_q;

    reveal_timer #(.SHOW_CYCLES(SHOW_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(TW'(SHOW_CYCLES - 1)),
        .done    (tmr_done)
    );

`ifdef MEMORY_GAME_MISS_LIMIT_EN
    logic [3:0] miss_q, miss_d;
    logic lose_q, lose_d;
    // A mismatch can never complete the board, so win needs no extra priority here.
    assign out_of_misses = state_q == RESOLVE && !pair_eq && miss_q + 4'd1 == 4'(MAX_MISSES);
    assign miss_d = load ? '0 : (state_q == RESOLVE && !pair_eq) ? miss_q + 4'd1 : miss_q;
    assign lose_d = load ? 1'b0 : lose_q | out_of_misses;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            miss_q <= '0;
            lose_q <= 1'b0;
        end else begin
            miss_q <= miss_d;
            lose_q <= lose_d;
        end
    assign lose = lose_q;
`else
    assign out_of_misses = 1'b0;
    assign lose = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        revealed_d = revealed_q;
        matched_d = matched_q;
        idx1_d = idx1_q;
        idx2_d = idx2_q;
        tries_d = tries_q;
        win_d = win_q;
        sel_err_d = 1'b0;
        if (load) begin
            state_d = PICK1;
            revealed_d = '0;
            matched_d = '0;
            tries_d = '0;
            win_d = 1'b0;
        end else begin
            case (state_q)
                PICK1: if (sel_valid) begin
                    if (sel_free) begin
                        idx1_d = sel;
                        revealed_d = revealed_q | sel_bit;
                        state_d = PICK2;
                    end else sel_err_d = 1'b1;
                end
                PICK2: if (sel_valid) begin
                    if (tmr_load) begin
                        idx2_d = sel;
                        revealed_d = revealed_q | sel_bit;
                        state_d = SHOW;
                    end else sel_err_d = 1'b1;
                end
                SHOW: state_d = tmr_done ? RESOLVE : SHOW;
                RESOLVE: begin
                    tries_d = tries_q + {7'd0, tries_q != 8'hFF};
                    matched_d = new_matched;
                    revealed_d = new_matched;
                    win_d = new_matched == ALL_MATCHED;
                    state_d = (win_d || out_of_misses) ? DONE : PICK1;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= IDLE;
            cards_q <= '0;
            revealed_q <= '0;
            matched_q <= '0;
            idx1_q <= '0;
            idx2_q <= '0;
            tries_q <= '0;
            sel_err_q <= 1'b0;
            win_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) cards_q <= {card_f, card_e, card_d, card_c, card_b, card_a};
            revealed_q <= revealed_d;
            matched_q <= matched_d;
            idx1_q <= idx1_d;
            idx2_q <= idx2_d;
            tries_q <= tries_d;
            sel_err_q <= sel_err_d;
            win_q <= win_d;
        end

    assign revealed = revealed_q;
    assign matched = matched_q;
    assign tries = tries_q;
    assign sel_err = sel_err_q;
    assign win = win_q;
    assign busy = state_q == SHOW || state_q == RESOLVE;
endmodule

// File: doc/pair_match_checker.md
Name: pair_match_checker

Overview:
- Downstream consumer of the card generator (memoryPairs).
- Latches the six 4-bit card values A..F on a load pulse, then runs one game of pairs against the player's selections.
- Player selections arrive as a card index plus a one-cycle confirm pulse from the debounced switch/button front end.
- Drives the revealed/matched masks to the display stage, plus try count, win/lose and a selection-error pulse.

Parameters:
- SHOW_CYCLES, 4: cycles both picked cards stay revealed before resolution; minimum 1. Board top level overrides with a ~0.5 s count.
- MAX_MISSES, 8: mismatches allowed before loss. Used only with MISS_LIMIT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- load  in  1  one-cycle pulse: latch card_a..card_f and start a new game
- card_a..card_f  in  4 each  card values from the generator; sampled only on load
- sel  in  3  selected card index, 0=a .. 5=f
- sel_valid  in  1  one-cycle confirm pulse for sel
- revealed  out  6  bit i = card i face-up (matched or currently picked)
- matched  out  6  bit i = card i permanently matched
- tries  out  8  resolved pick-pairs, saturates at 255
- busy  out  1  high in SHOW and RESOLVE
- sel_err  out  1  one-cycle pulse on a rejected selection
- win  out  1  all six cards matched; held until load
- lose  out  1  miss limit reached; held until load (constant 0 without MISS_LIMIT_EN)

Behaviour:
- Reset (rst=0, asynchronous), all outputs and registers cleared:
  - state=IDLE; revealed, matched, tries, sel_err, win, lose, busy = 0.
  - Card registers = 0; timer = 0; miss count = 0.
- load has priority over everything in every state. Next edge:
  - cards latched; matched=0, revealed=0, tries=0, misses=0, win=lose=0; state=PICK1.
- IDLE: ignore sel_valid.
- PICK1, on sel_valid:
  - Accept when sel<6 and matched[sel]=0: idx1=sel, revealed[sel]=1 on next edge, go PICK2.
  - Otherwise sel_err=1 for exactly the next cycle; stay in PICK1.
- PICK2, on sel_valid:
  - Accept when sel<6, matched[sel]=0 and sel!=idx1: idx2=sel, revealed[sel]=1, timer=SHOW_CYCLES-1, go SHOW.
  - Otherwise sel_err pulse; stay in PICK2.
- SHOW:
  - busy=1; sel_valid ignored (no sel_err).
  - Timer decrements each cycle; when timer=0, next edge goes to RESOLVE.
- RESOLVE (one cycle, busy=1), next edge:
  - tries = tries+1, saturating at 255.
  - If card[idx1]==card[idx2]: matched |= both bits.
  - revealed = updated matched (picks hidden if mismatched).
  - If updated matched = 6'b111111: win=1, state DONE; else state PICK1.
- DONE: outputs hold; sel_valid ignored; only load or reset leaves.
- Latency, second pick accepted at edge k:
  - revealed bit set after edge k.
  - Resolution (matched/tries/revealed update) visible after edge k+SHOW_CYCLES+1.
  - First pick after that is accepted from cycle k+SHOW_CYCLES+1.
- Equal values in two different pairs are allowed; the match rule is value equality only.
- Reset mid-game aborts immediately; no partial state survives.

Optional Feature:
- Macro: MEMORY_GAME_MISS_LIMIT_EN.
- With the macro:
  - 4-bit miss counter increments on each mismatching RESOLVE.
  - When it reaches MAX_MISSES on that RESOLVE, next edge sets lose=1, state DONE; revealed shows matched only.
  - A match on the same RESOLVE never counts as a miss.
  - Win is checked before lose.
- Without the macro: no miss counter; lose tied to 0; game continues indefinitely.

Decomposition:
- Package memory_game_pkg:
  - NUM_CARDS=6, CARD_W=4, IDX_W=3, ALL_MATCHED=6'b111111.
  - State encoding IDLE/PICK1/PICK2/SHOW/RESOLVE/DONE.
- One sub-module: reveal_timer.
  - Loadable down-counter, width derived from SHOW_CYCLES.
  - Ports clk, rst, load, load_val, done (high when count=0).
- The FSM and card registers stay in pair_match_checker.

Test Plan:
1. Reset then load with cards 1,2,3,1,2,3; pick 0 then 3; SHOW_CYCLES=4 -> revealed=000001 then 001001; after 5 cycles matched=001001, tries=1, busy low.
2. Same cards; pick 0 then 1 -> revealed=000011 during SHOW; after resolve matched=0, revealed=0, tries=1.
3. Errors:
   - In PICK2 after pick 2, select 2 again -> sel_err one cycle.
   - sel=7 -> sel_err.
   - Select an already-matched card -> sel_err.
   - In every case state and masks are unchanged.
4. Full game: pairs (0,3),(1,4),(2,5) -> win=1, matched=111111, tries=3; later sel_valid ignored; load clears win and tries.
5. Reset and load edge cases:
   - Assert rst low during SHOW -> all outputs 0 asynchronously, before the next clk edge.
   - Assert load during SHOW -> restart in PICK1 with revealed=0.
6. With MEMORY_GAME_MISS_LIMIT_EN, MAX_MISSES=2: two mismatches -> lose=1 after second RESOLVE, sel_valid ignored; without the macro, lose stays 0.
